jk_updown_counter: RTL and testbench
====================================

// Module: jk_updown_counter
// PURPOSE
//  Parametrised modulo-M up/down counter; successor to the fixed-direction JK ripple-enable counter.
//  Adds direction control, count enable, synchronous parallel load, programmable modulus and a registered wrap pulse.
//  Built from JK flip-flops with asynchronous clear.
//  Serves as the timebase/index generator for sequencing blocks: address walkers, divided strobes.
// PARAMETERS
//  N        4    counter width in bits
//  MODULUS  16   count range 0..MODULUS-1; legal 2 <= MODULUS <= 2**N; elaboration error otherwise
// PORTS
//  clk     input   1  rising-edge clock
//  rst_n   input   1  asynchronous, active-low reset
//  en      input   1  count enable; ignored while load=1
//  up      input   1  direction: 1 = increment, 0 = decrement
//  load    input   1  synchronous parallel load of d
//  d       input   N  load value
//  q       output  N  current count (flip-flop outputs, registered)
//  tc      output  1  combinational terminal count: en & ~load & (up ? q==MODULUS-1 : q==0)
//  wrap    output  1  registered one-cycle pulse, high in the cycle after q wrapped
// BEHAVIOUR
//  - Reset: rst_n low forces q=0 and wrap=0 immediately, independent of clk; asynchronous assertion.
//    Counting resumes on the first rising clk edge with rst_n high.
//  - Reset mid-count: the count is lost; no partial state survives; wrap is cleared even if pending.
//  - Priority per rising edge: load > en > hold.
//  - load=1: q <= (d <= MODULUS-1) ? d : MODULUS-1 (out-of-range value saturates); wrap <= 0.
//  - en=1, up=1: q == MODULUS-1 -> q <= 0, wrap <= 1; otherwise q <= q+1, wrap <= 0.
//  - en=1, up=0: q == 0 -> q <= MODULUS-1, wrap <= 1; otherwise q <= q-1, wrap <= 0.
//  - en=0, load=0: q holds; wrap <= 0.
//  - Latency: q reflects an action one cycle after the sampling edge.
//    wrap is high exactly in the cycle where q shows the post-wrap value.
//  - up may change any cycle; a direction flip takes effect on the next enabled edge with no dead cycle.
//  - Unreachable states (q >= MODULUS, non-power-of-two MODULUS only) are entered only by X/SEU.
//    Next enabled edge maps them to 0 (up) or MODULUS-1 (down) and asserts wrap.
//  - Arithmetic is modulo MODULUS, never modulo 2**N; the N-bit adder carry is not exposed.
// STRUCTURE
//  - Per bit, J = nxt[i] & ~q[i] and K = ~nxt[i] & q[i], where nxt is the next-state vector from load/en/up/wrap logic.
//  - When MODULUS == 2**N, nxt reduces to a toggle chain:
//    t[i] = en & (up ? &q[i-1:0] : &~q[i-1:0]); J = K = t[i].
//  - Generate loop over N bits; one JK cell per bit.
//  - Single sub-module jkflipflop_ar: JK flip-flop with async active-low clear.
//    Ports: clk, rst_n, j, k, q, qn.
//  - Shared gate/delay macros go in the common gates include.
//  - MODULUS legality check sits in a shared counter-constants header, with localparam MAXV = MODULUS-1.
//  - No other sub-modules.
// TESTING (N=4, MODULUS=10 unless noted)
//  - Reset: drive rst_n=0 mid-cycle with q=7 -> q=0 and wrap=0 before the next edge; held for 3 edges.
//  - Up wrap: en=1, up=1 from 0 -> sequence 0..9,0; wrap high only with q=0; tc high when q=9.
//  - Down wrap: en=1, up=0 from 2 -> 2,1,0,9,8; wrap high only with q=9; tc high when q=0.
//  - Load priority: load=1, en=1, d=5 -> q=5, wrap=0.
//    load d=13 -> q=9; next edge with en, up -> q=0 and wrap=1.
//  - Direction flip: up count to 4, set up=0 for 1 edge, then up=1 -> 4,3,4.
//    Hold with en=0 for 5 edges -> q stays 4.
//  - Power-of-two: N=4, MODULUS=16, up from 14 -> 14,15,0 with wrap.
//    Down from 0 -> 15 with wrap.
//    Compare q against a behavioural modulo model for 1000 random en/up/load cycles.

Source files
------------

// File: rtl/jk_updown_counter_pkg.sv
// Shared types and elaboration helpers for the JK up/down counter.
package jk_updown_counter_pkg;

    // Action selected on a rising edge, in priority order load > count > hold.
    typedef enum logic [1:0] {
        ACT_HOLD = 2'd0,
        ACT_LOAD = 2'd1,
        ACT_UP   = 2'd2,
        ACT_DOWN = 2'd3
    } count_act_t;

    // A modulus is legal when 2 <= MODULUS <= 2**N.
    function automatic bit modulus_legal(input int n, input int m);
        return (n >= 1) && (n <= 30) && (m >= 2) && (m <= (1 << n));
    endfunction

    // Collapse the control inputs into one action; load always wins over en.
    function automatic count_act_t decode_act(input logic en, input logic up, input logic load);
        if (load)
            return ACT_LOAD;
        else if (en)
            return up ? ACT_UP : ACT_DOWN;
        else
            return ACT_HOLD;
    endfunction

endpackage

// File: rtl/jk_updown_counter_jkflipflop_ar.sv
// JK flip-flop with asynchronous active-low clear; one cell per counter bit.
module jkflipflop_ar (
    input  logic clk,
    input  logic rst_n,
    input  logic j,
    input  logic k,
    output logic q,
    output logic qn
);

    // Classic JK behaviour: hold, reset, set, toggle; cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= 1'b0;
        end else begin
            case ({j, k})
                2'b01:   q <= 1'b0;
                2'b10:   q <= 1'b1;
                2'b11:   q <= ~q;
                default: q <= q;
            endcase
        end
    end

    assign qn = ~q;

endmodule

// File: rtl/jk_updown_counter.sv
// Modulo-MODULUS up/down counter built from JK flip-flops, with parallel
// load, count enable, combinational terminal count and a registered wrap pulse.
module jk_updown_counter
    import jk_updown_counter_pkg::*;
#(
    parameter int N       = 4,
    parameter int MODULUS = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         up,
    input  logic         load,
    input  logic [N-1:0] d,
    output logic [N-1:0] q,
    output logic         tc,
    output logic         wrap
);

    localparam int           MAXV   = MODULUS - 1;
    localparam logic [N-1:0] MAXV_Q = N'(MAXV);
    localparam logic [N-1:0] ONE    = N'(1);
    localparam bit           POW2   = (MODULUS == (1 << N));

    generate
        if (!modulus_legal(N, MODULUS)) begin : g_bad_modulus
            $error("jk_updown_counter: MODULUS must satisfy 2 <= MODULUS <= 2**N");
        end
    endgenerate

    count_act_t   act;
    logic [N-1:0] qn;
    logic [N-1:0] nxt;
    logic         wrap_nxt;
    logic [N-1:0] j;
    logic [N-1:0] k;

    // Next count and wrap flag; states at or above MODULUS fold back like a wrap.
    always_comb begin
        act      = decode_act(en, up, load);
        nxt      = q;
        wrap_nxt = 1'b0;
        case (act)
            ACT_LOAD: begin
                nxt = (d > MAXV_Q) ? MAXV_Q : d;
            end
            ACT_UP: begin
                if (q >= MAXV_Q) begin
                    nxt      = '0;
                    wrap_nxt = 1'b1;
                end else begin
                    nxt = q + ONE;
                end
            end
            ACT_DOWN: begin
                if ((q == '0) || (q > MAXV_Q)) begin
                    nxt      = MAXV_Q;
                    wrap_nxt = 1'b1;
                end else begin
                    nxt = q - ONE;
                end
            end
            default: begin
                nxt = q;
            end
        endcase
    end

    // One JK cell per bit. A full binary range counts with a plain toggle
    // chain; any other modulus steers J/K from the computed next state.
    generate
        for (genvar i = 0; i < N; i++) begin : g_bit
            if (POW2) begin : g_tog
                logic t;
                if (i == 0) begin : g_lsb
                    assign t = en;
                end else begin : g_upper
                    assign t = en & (up ? (&q[i-1:0]) : (&qn[i-1:0]));
                end
                assign j[i] = load ? (nxt[i] & qn[i])  : t;
                assign k[i] = load ? (~nxt[i] & q[i])  : t;
            end else begin : g_mod
                assign j[i] = nxt[i] & qn[i];
                assign k[i] = ~nxt[i] & q[i];
            end

            jkflipflop_ar u_ff (
                .clk   (clk),
                .rst_n (rst_n),
                .j     (j[i]),
                .k     (k[i]),
                .q     (q[i]),
                .qn    (qn[i])
            );
        end
    endgenerate

    // Wrap pulse: high for the single cycle in which q shows the post-wrap value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrap <= 1'b0;
        end else begin
            wrap <= wrap_nxt;
        end
    end

    assign tc = en & ~load & (up ? (q == MAXV_Q) : (q == '0));

endmodule

// File: tb/tb_jk_updown_counter.sv
// Bench for jk_updown_counter: a modulo-10 and a modulo-16 instance checked
// with directed scenarios and randomized traffic against a modulo-arithmetic model.
module tb_jk_updown_counter;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;

    logic       e10 = 1'b0, u10 = 1'b1, l10 = 1'b0;
    logic [3:0] d10 = 4'd0;
    logic [3:0] q10;
    logic       tc10, w10;

    logic       e16 = 1'b0, u16 = 1'b1, l16 = 1'b0;
    logic [3:0] d16 = 4'd0;
    logic [3:0] q16;
    logic       tc16, w16;

    int checks   = 0;
    int failures = 0;

    int exp10 = 0, exp16 = 0;
    bit wexp10 = 1'b0, wexp16 = 1'b0;

    jk_updown_counter #(.N(4), .MODULUS(10)) dut10 (
        .clk(clk), .rst_n(rst_n), .en(e10), .up(u10), .load(l10),
        .d(d10), .q(q10), .tc(tc10), .wrap(w10)
    );

    jk_updown_counter #(.N(4), .MODULUS(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .en(e16), .up(u16), .load(l16),
        .d(d16), .q(q16), .tc(tc16), .wrap(w16)
    );

    always #5 clk = ~clk;

    // Reference: next count in plain modulo-m arithmetic.
    function automatic void model(input int m, input int cur, input bit en, input bit up,
                                  input bit load, input int d, output int nq, output bit nw);
        nw = 1'b0;
        nq = cur;
        if (load) begin
            nq = (d > m - 1) ? m - 1 : d;
        end else if (en) begin
            if (up) begin
                nq = (cur + 1) % m;
                nw = (cur == m - 1);
            end else begin
                nq = (cur + m - 1) % m;
                nw = (cur == 0);
            end
        end
    endfunction

    function automatic bit tc_model(input int m, input int cur, input bit en, input bit up, input bit load);
        return en && !load && (up ? (cur == m - 1) : (cur == 0));
    endfunction

    // Advance one clock, updating both reference models from the applied inputs.
    task automatic tick();
        int n10, n16;
        bit nw10, nw16;
        model(10, exp10, e10, u10, l10, int'(d10), n10, nw10);
        model(16, exp16, e16, u16, l16, int'(d16), n16, nw16);
        @(posedge clk);
        #1;
        exp10 = n10; wexp10 = nw10;
        exp16 = n16; wexp16 = nw16;
    endtask

    task automatic idle_all();
        e10 = 1'b0; l10 = 1'b0; u10 = 1'b1; d10 = 4'd0;
        e16 = 1'b0; l16 = 1'b0; u16 = 1'b1; d16 = 4'd0;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (q10 !== 4'd0 || w10 !== 1'b0 || q16 !== 4'd0 || w16 !== 1'b0) begin
            failures++;
            $display("FAIL reset_init q10=%0d w10=%0b q16=%0d w16=%0b required 0/0/0/0", q10, w10, q16, w16);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp10 = 0; wexp10 = 0; exp16 = 0; wexp16 = 0;

        // Load 7, then pull reset in the middle of a cycle with counting enabled.
        l10 = 1'b1; d10 = 4'd7;
        tick();
        l10 = 1'b0; e10 = 1'b1; u10 = 1'b1;
        checks++;
        if (q10 !== 4'd7) begin
            failures++;
            $display("FAIL reset_preload q=%0d required 7", q10);
        end
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (q10 !== 4'd0 || w10 !== 1'b0) begin
            failures++;
            $display("FAIL reset_async q=%0d wrap=%0b required 0/0", q10, w10);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if (q10 !== 4'd0 || w10 !== 1'b0) begin
                failures++;
                $display("FAIL reset_hold edge=%0d q=%0d wrap=%0b required 0/0", i, q10, w10);
            end
        end
        rst_n = 1'b1;
        exp10 = 0; wexp10 = 0; exp16 = 0; wexp16 = 0;

        // A pending wrap pulse must be cleared by reset.
        e10 = 1'b0; l10 = 1'b1; d10 = 4'd9;
        tick();
        l10 = 1'b0; e10 = 1'b1; u10 = 1'b1;
        tick();
        checks++;
        if (q10 !== 4'd0 || w10 !== 1'b1) begin
            failures++;
            $display("FAIL reset_wrap_setup q=%0d wrap=%0b required 0/1", q10, w10);
        end
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (w10 !== 1'b0 || q10 !== 4'd0) begin
            failures++;
            $display("FAIL reset_wrap_clear q=%0d wrap=%0b required 0/0", q10, w10);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp10 = 0; wexp10 = 0; exp16 = 0; wexp16 = 0;
        idle_all();
    endtask

    task automatic test_up_wrap();
        l10 = 1'b1; d10 = 4'd0;
        tick();
        l10 = 1'b0; e10 = 1'b1; u10 = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            #1;
            checks++;
            if (tc10 !== ((i - 1) == 9)) begin
                failures++;
                $display("FAIL up_tc q=%0d tc=%0b required %0b", q10, tc10, (i - 1) == 9);
            end
            tick();
            checks++;
            if (q10 !== 4'(i % 10) || w10 !== (i == 10)) begin
                failures++;
                $display("FAIL up_wrap step=%0d q=%0d wrap=%0b required %0d/%0b", i, q10, w10, i % 10, i == 10);
            end
        end
        idle_all();
    endtask

    task automatic test_down_wrap();
        int seq[4]  = '{1, 0, 9, 8};
        bit wseq[4] = '{0, 0, 1, 0};
        bit tseq[4] = '{0, 0, 1, 0};
        l10 = 1'b1; d10 = 4'd2;
        tick();
        l10 = 1'b0; e10 = 1'b1; u10 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (tc10 !== tseq[i]) begin
                failures++;
                $display("FAIL down_tc q=%0d tc=%0b required %0b", q10, tc10, tseq[i]);
            end
            tick();
            checks++;
            if (q10 !== 4'(seq[i]) || w10 !== wseq[i]) begin
                failures++;
                $display("FAIL down_wrap step=%0d q=%0d wrap=%0b required %0d/%0b", i, q10, w10, seq[i], wseq[i]);
            end
        end
        idle_all();
    endtask

    task automatic test_load_priority();
        l10 = 1'b1; e10 = 1'b1; u10 = 1'b1; d10 = 4'd5;
        #1;
        checks++;
        if (tc10 !== 1'b0) begin
            failures++;
            $display("FAIL load_tc_mask tc=%0b required 0", tc10);
        end
        tick();
        checks++;
        if (q10 !== 4'd5 || w10 !== 1'b0) begin
            failures++;
            $display("FAIL load_prio q=%0d wrap=%0b required 5/0", q10, w10);
        end
        d10 = 4'd13;
        tick();
        checks++;
        if (q10 !== 4'd9 || w10 !== 1'b0) begin
            failures++;
            $display("FAIL load_sat q=%0d wrap=%0b required 9/0", q10, w10);
        end
        l10 = 1'b0;
        tick();
        checks++;
        if (q10 !== 4'd0 || w10 !== 1'b1) begin
            failures++;
            $display("FAIL load_sat_wrap q=%0d wrap=%0b required 0/1", q10, w10);
        end
        idle_all();
    endtask

    task automatic test_direction_flip();
        l10 = 1'b1; d10 = 4'd0;
        tick();
        l10 = 1'b0; e10 = 1'b1; u10 = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if (q10 !== 4'd4) begin
            failures++;
            $display("FAIL flip_start q=%0d required 4", q10);
        end
        u10 = 1'b0;
        tick();
        checks++;
        if (q10 !== 4'd3) begin
            failures++;
            $display("FAIL flip_down q=%0d required 3", q10);
        end
        u10 = 1'b1;
        tick();
        checks++;
        if (q10 !== 4'd4) begin
            failures++;
            $display("FAIL flip_up q=%0d required 4", q10);
        end
        e10 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            u10 = 1'(i % 2);
            tick();
            checks++;
            if (q10 !== 4'd4 || w10 !== 1'b0) begin
                failures++;
                $display("FAIL hold edge=%0d q=%0d wrap=%0b required 4/0", i, q10, w10);
            end
        end
        idle_all();
    endtask

    task automatic test_pow2();
        l16 = 1'b1; d16 = 4'd14;
        tick();
        l16 = 1'b0; e16 = 1'b1; u16 = 1'b1;
        tick();
        checks++;
        if (q16 !== 4'd15 || w16 !== 1'b0) begin
            failures++;
            $display("FAIL pow2_up15 q=%0d wrap=%0b required 15/0", q16, w16);
        end
        tick();
        checks++;
        if (q16 !== 4'd0 || w16 !== 1'b1) begin
            failures++;
            $display("FAIL pow2_upwrap q=%0d wrap=%0b required 0/1", q16, w16);
        end
        u16 = 1'b0;
        #1;
        checks++;
        if (tc16 !== 1'b1) begin
            failures++;
            $display("FAIL pow2_tc_down tc=%0b required 1", tc16);
        end
        tick();
        checks++;
        if (q16 !== 4'd15 || w16 !== 1'b1) begin
            failures++;
            $display("FAIL pow2_downwrap q=%0d wrap=%0b required 15/1", q16, w16);
        end
        idle_all();
    endtask

    task automatic test_random();
        for (int c = 0; c < 1000; c++) begin
            e10 = 1'($urandom_range(0, 1));
            u10 = 1'($urandom_range(0, 1));
            l10 = ($urandom_range(0, 7) == 0);
            d10 = 4'($urandom_range(0, 15));
            e16 = 1'($urandom_range(0, 1));
            u16 = 1'($urandom_range(0, 1));
            l16 = ($urandom_range(0, 7) == 0);
            d16 = 4'($urandom_range(0, 15));
            #1;
            checks++;
            if (tc10 !== tc_model(10, exp10, e10, u10, l10) || tc16 !== tc_model(16, exp16, e16, u16, l16)) begin
                failures++;
                $display("FAIL rand_tc cycle=%0d tc10=%0b tc16=%0b required %0b/%0b", c, tc10, tc16,
                         tc_model(10, exp10, e10, u10, l10), tc_model(16, exp16, e16, u16, l16));
            end
            tick();
            checks++;
            if (q10 !== 4'(exp10) || w10 !== wexp10) begin
                failures++;
                $display("FAIL rand_m10 cycle=%0d q=%0d wrap=%0b required %0d/%0b", c, q10, w10, exp10, wexp10);
            end
            checks++;
            if (q16 !== 4'(exp16) || w16 !== wexp16) begin
                failures++;
                $display("FAIL rand_m16 cycle=%0d q=%0d wrap=%0b required %0d/%0b", c, q16, w16, exp16, wexp16);
            end
        end
        idle_all();
    endtask

    initial begin
        test_reset();
        test_up_wrap();
        test_down_wrap();
        test_load_priority();
        test_direction_flip();
        test_pow2();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
